// File: rtl/exe_mem_stage.sv
// Execute stage: single-cycle ALU/branch/JAL, iterative shift-add multiply, EXE/MEM register.
// Latency: 1 cycle for non-MUL ops, DSIZE+1 cycles for MUL; stall_out holds upstream while a multiply runs.
module exe_mem_stage #(
  parameter int DSIZE = 32,
  parameter int ISIZE = 32,
  parameter int ASIZE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [DSIZE-1:0] imm_in,
  input  logic [2:0]       opcode_in,
  input  logic             alusrc_in,
  input  logic [ASIZE-1:0] waddr_in,
  input  logic             wen_in,
  input  logic             memWrite_in,
  input  logic             memRead_in,
  input  logic             memToReg_in,
  input  logic             branch_in,
  input  logic             jal_in,
  input  logic [ISIZE-1:0] PC_in,
  output logic             stall_out,
  output logic             redirect_out,
  output logic [ISIZE-1:0] target_out,
  output logic [DSIZE-1:0] result_out,
  output logic [DSIZE-1:0] wdata_out,
  output logic [ASIZE-1:0] waddr_out,
  output logic             wen_out,
  output logic             memWrite_out,
  output logic             memRead_out,
  output logic             memToReg_out
);

  localparam int CW = $clog2(DSIZE);
  localparam logic [2:0] OP_MUL = 3'b101;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [DSIZE-1:0] mcand_q, mcand_d;
  logic [DSIZE-1:0] mplier_q, mplier_d;
  logic [DSIZE-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DSIZE-1:0] result_q, result_d;
  logic [DSIZE-1:0] wdata_q, wdata_d;
  logic [ASIZE-1:0] waddr_q, waddr_d;
  logic             wen_q, wen_d;
  logic             mem_wr_q, mem_wr_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem2reg_q, mem2reg_d;

  logic [DSIZE-1:0] op_b;
  logic [DSIZE-1:0] alu_res;
  logic [DSIZE-1:0] acc_sum;
  logic [ISIZE-1:0] pc_plus1;
  logic             is_mul;
  logic             mul_last;

  always_comb begin
    op_b = alusrc_in ? imm_in : rdata2_in;
    case (opcode_in)
      3'b000:  alu_res = rdata1_in + op_b;
      3'b001:  alu_res = rdata1_in - op_b;
      3'b010:  alu_res = rdata1_in & op_b;
      3'b011:  alu_res = rdata1_in | op_b;
      3'b100:  alu_res = {{(DSIZE-1){1'b0}}, ($signed(rdata1_in) < $signed(op_b))};
      3'b110:  alu_res = rdata1_in << op_b[4:0];
      3'b111:  alu_res = rdata1_in >> op_b[4:0];
      default: alu_res = '0;
    endcase
    pc_plus1 = PC_in + ISIZE'(1);
    is_mul   = valid_in && (opcode_in == OP_MUL);
    mul_last = (state_q == BUSY) && (cnt_q == CW'(DSIZE-1));
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Combinational outputs are forced low during reset so a held MUL cannot stall a reset pipeline.
  assign stall_out    = rst && (((state_q == IDLE) && is_mul) || ((state_q == BUSY) && !mul_last));
  assign redirect_out = rst && valid_in && (state_q == IDLE) &&
                        (jal_in || (branch_in && (rdata1_in == rdata2_in)));
  assign target_out   = rst ? (PC_in + imm_in[ISIZE-1:0]) : '0;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = '0;
    wdata_d   = '0;
    waddr_d   = '0;
    wen_d     = 1'b0;
    mem_wr_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem2reg_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (is_mul) begin
          state_d  = BUSY;
          mcand_d  = rdata1_in;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
        end else if (valid_in) begin
          result_d  = jal_in ? DSIZE'(pc_plus1) : alu_res;
          wdata_d   = rdata2_in;
          waddr_d   = waddr_in;
          wen_d     = wen_in;
          mem_wr_d  = memWrite_in;
          mem_rd_d  = memRead_in;
          mem2reg_d = memToReg_in;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Upstream is still holding the MUL, so its control comes straight from the inputs.
        if (mul_last) begin
          state_d   = IDLE;
          result_d  = acc_sum;
          wdata_d   = rdata2_in;
          waddr_d   = waddr_in;
          wen_d     = wen_in;
          mem_wr_d  = memWrite_in;
          mem_rd_d  = memRead_in;
          mem2reg_d = memToReg_in;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      wdata_q   <= '0;
      waddr_q   <= '0;
      wen_q     <= 1'b0;
      mem_wr_q  <= 1'b0;
      mem_rd_q  <= 1'b0;
      mem2reg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      wdata_q   <= wdata_d;
      waddr_q   <= waddr_d;
      wen_q     <= wen_d;
      mem_wr_q  <= mem_wr_d;
      mem_rd_q  <= mem_rd_d;
      mem2reg_q <= mem2reg_d;
    end
  end

  assign result_out   = result_q;
  assign wdata_out    = wdata_q;
  assign waddr_out    = waddr_q;
  assign wen_out      = wen_q;
  assign memWrite_out = mem_wr_q;
  assign memRead_out  = mem_rd_q;
  assign memToReg_out = mem2reg_q;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: directed scenarios plus randomized ALU and MUL traffic against an arithmetic reference.
module tb_exe_mem_stage;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] rdata1_in, rdata2_in, imm_in, PC_in;
  logic [2:0]  opcode_in;
  logic        alusrc_in;
  logic [4:0]  waddr_in;
  logic        wen_in, memWrite_in, memRead_in, memToReg_in, branch_in, jal_in;
  logic        stall_out, redirect_out;
  logic [31:0] target_out, result_out, wdata_out;
  logic [4:0]  waddr_out;
  logic        wen_out, memWrite_out, memRead_out, memToReg_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_mem_stage #(.DSIZE(32), .ISIZE(32), .ASIZE(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in),
    .opcode_in(opcode_in), .alusrc_in(alusrc_in), .waddr_in(waddr_in),
    .wen_in(wen_in), .memWrite_in(memWrite_in), .memRead_in(memRead_in),
    .memToReg_in(memToReg_in), .branch_in(branch_in), .jal_in(jal_in),
    .PC_in(PC_in), .stall_out(stall_out), .redirect_out(redirect_out),
    .target_out(target_out), .result_out(result_out), .wdata_out(wdata_out),
    .waddr_out(waddr_out), .wen_out(wen_out), .memWrite_out(memWrite_out),
    .memRead_out(memRead_out), .memToReg_out(memToReg_out)
  );

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd5: return a * b;
      3'd6: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic src, input logic [4:0] wa, input logic w,
                       input logic mw, input logic mr, input logic m2r, input logic br, input logic j,
                       input logic [31:0] pc);
    valid_in = v; opcode_in = op; rdata1_in = a; rdata2_in = b; imm_in = imm; alusrc_in = src;
    waddr_in = wa; wen_in = w; memWrite_in = mw; memRead_in = mr; memToReg_in = m2r;
    branch_in = br; jal_in = j; PC_in = pc;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++; if ({result_out, wdata_out, waddr_out, wen_out, memWrite_out, memRead_out, memToReg_out} !== '0) begin
      errors++; $display("FAIL reset_regs: result=%h wdata=%h waddr=%0d wen=%b, required all 0", result_out, wdata_out, waddr_out, wen_out); end
    checks++; if (stall_out !== 1'b0 || redirect_out !== 1'b0) begin
      errors++; $display("FAIL reset_comb: stall=%b redirect=%b, required 0 0", stall_out, redirect_out); end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_add();
    drive(1, 3'd0, 32'd5, 32'd7, 32'd0, 0, 5'd3, 1, 0, 0, 0, 0, 0, 32'd0);
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL add_stall: got %b required 0", stall_out); end
    @(posedge clk); #1;
    checks++; if (result_out !== 32'd12 || waddr_out !== 5'd3 || wen_out !== 1'b1) begin
      errors++; $display("FAIL add: result=%0d waddr=%0d wen=%b, required 12 3 1", result_out, waddr_out, wen_out); end
  endtask

  task automatic test_branch();
    drive(1, 3'd1, 32'd9, 32'd9, 32'hFFFF_FFFC, 0, 5'd0, 0, 0, 0, 0, 1, 0, 32'd20);
    #1;
    checks++; if (redirect_out !== 1'b1 || target_out !== 32'd16) begin
      errors++; $display("FAIL branch_taken: redirect=%b target=%0d, required 1 16", redirect_out, target_out); end
    @(posedge clk); #1;
    checks++; if (wen_out !== 1'b0) begin errors++; $display("FAIL branch_wen: got %b required 0", wen_out); end
    drive(1, 3'd1, 32'd9, 32'd8, 32'hFFFF_FFFC, 0, 5'd0, 0, 0, 0, 0, 1, 0, 32'd20);
    #1;
    checks++; if (redirect_out !== 1'b0) begin errors++; $display("FAIL branch_not_taken: got %b required 0", redirect_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_jal();
    drive(1, 3'd0, 32'd123, 32'd456, 32'd10, 1, 5'd1, 1, 0, 0, 0, 0, 1, 32'd40);
    #1;
    checks++; if (redirect_out !== 1'b1 || target_out !== 32'd50) begin
      errors++; $display("FAIL jal_redirect: redirect=%b target=%0d, required 1 50", redirect_out, target_out); end
    @(posedge clk); #1;
    checks++; if (result_out !== 32'd41 || wen_out !== 1'b1) begin
      errors++; $display("FAIL jal_link: result=%0d wen=%b, required 41 1", result_out, wen_out); end
  endtask

  task automatic test_alu_corners();
    logic [2:0]  ops [3] = '{3'd4, 3'd7, 3'd0};
    logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [3] = '{32'd1, 32'd31, 32'd1};
    logic [31:0] exp [3] = '{32'd1, 32'd1, 32'd0};
    for (int i = 0; i < 3; i++) begin
      drive(1, ops[i], as[i], bs[i], 32'd0, 0, 5'd9, 1, 0, 0, 0, 0, 0, 32'd0);
      @(posedge clk); #1;
      checks++; if (result_out !== exp[i]) begin
        errors++; $display("FAIL alu_corner%0d: op=%0d result=%h required %h", i, ops[i], result_out, exp[i]); end
    end
  endtask

  task automatic test_random_alu();
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b, imm, pc, bsel, eres, etgt;
      logic        v, src, br, j, w, mw, mr, m2r, eredir;
      logic [4:0]  wa;
      op = 3'($urandom_range(0, 7)); if (op == 3'd5) op = 3'd6;
      a = $urandom; b = $urandom; if ($urandom_range(0, 3) == 0) b = a;
      imm = $urandom; pc = $urandom; src = 1'($urandom); wa = 5'($urandom);
      v = ($urandom_range(0, 5) != 0); br = 1'($urandom); j = ($urandom_range(0, 4) == 0);
      if (j) br = 1'b0;
      w = 1'($urandom); mw = 1'($urandom); mr = 1'($urandom); m2r = 1'($urandom);
      bsel   = src ? imm : b;
      eres   = j ? pc + 32'd1 : ref_alu(op, a, bsel);
      eredir = v && (j || (br && a == b));
      etgt   = pc + imm;
      drive(v, op, a, b, imm, src, wa, w, mw, mr, m2r, br, j, pc);
      #1;
      checks++; if (redirect_out !== eredir || target_out !== etgt || stall_out !== 1'b0) begin
        errors++; $display("FAIL rand_comb%0d: redirect=%b target=%h stall=%b, required %b %h 0", i, redirect_out, target_out, stall_out, eredir, etgt); end
      @(posedge clk); #1;
      if (v) begin
        checks++; if (result_out !== eres || wdata_out !== b || waddr_out !== wa) begin
          errors++; $display("FAIL rand_data%0d: op=%0d result=%h wdata=%h waddr=%0d, required %h %h %0d", i, op, result_out, wdata_out, waddr_out, eres, b, wa); end
      end
      checks++; if ({wen_out, memWrite_out, memRead_out, memToReg_out} !== (v ? {w, mw, mr, m2r} : 4'b0)) begin
        errors++; $display("FAIL rand_ctrl%0d: ctrl=%b required %b", i, {wen_out, memWrite_out, memRead_out, memToReg_out}, v ? {w, mw, mr, m2r} : 4'b0); end
    end
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic src, input logic [31:0] imm);
    int st = 0;
    int bub = 0;
    logic [31:0] exp;
    exp = ref_alu(3'd5, a, src ? imm : b);
    drive(1, 3'd5, a, b, imm, src, 5'd7, 1, 0, 0, 1, 0, 0, 32'd100);
    for (int i = 0; i <= D; i++) begin
      #1;
      if (stall_out === 1'b1) st++;
      if (redirect_out !== 1'b0) st += 100;
      @(posedge clk); #1;
      if (i < D && {wen_out, memWrite_out, memRead_out, memToReg_out} === 4'b0) bub++;
    end
    checks++; if (st != D) begin errors++; $display("FAIL mul_stall_cycles: got %0d required %0d", st, D); end
    checks++; if (bub != D) begin errors++; $display("FAIL mul_bubbles: got %0d required %0d", bub, D); end
    checks++; if (result_out !== exp || wen_out !== 1'b1 || waddr_out !== 5'd7 || memToReg_out !== 1'b1) begin
      errors++; $display("FAIL mul_result: a=%h b=%h result=%h wen=%b waddr=%0d, required %h 1 7", a, b, result_out, wen_out, waddr_out, exp); end
  endtask

  task automatic test_mul();
    run_mul(32'hFFFF_FFFF, 32'd3, 0, 32'd0);
    checks++; if (result_out !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_directed: got %h required fffffffd", result_out); end
  endtask

  task automatic test_back_to_back();
    run_mul(32'd1234, 32'd5678, 0, 32'd0);
    run_mul($urandom, 32'd0, 1, $urandom);
    for (int i = 0; i < 2; i++) run_mul($urandom, $urandom, 0, 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    drive(1, 3'd5, 32'hDEAD_BEEF, 32'h1357_9BDF, 32'd0, 0, 5'd4, 1, 0, 0, 0, 0, 0, 32'd0);
    repeat (11) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (stall_out !== 1'b0 || redirect_out !== 1'b0 || target_out !== '0) begin
      errors++; $display("FAIL midmul_reset_comb: stall=%b redirect=%b target=%h, required 0 0 0", stall_out, redirect_out, target_out); end
    checks++; if ({result_out, wdata_out, waddr_out, wen_out, memWrite_out, memRead_out, memToReg_out} !== '0) begin
      errors++; $display("FAIL midmul_reset_regs: result=%h wen=%b, required 0 0", result_out, wen_out); end
    drive(1, 3'd0, 32'd2, 32'd3, 32'd0, 0, 5'd6, 1, 0, 0, 0, 0, 0, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL midmul_idle: stall=%b required 0", stall_out); end
    @(posedge clk); #1;
    checks++; if (result_out !== 32'd5 || wen_out !== 1'b1 || waddr_out !== 5'd6) begin
      errors++; $display("FAIL midmul_add: result=%0d wen=%b waddr=%0d, required 5 1 6", result_out, wen_out, waddr_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_jal();
    test_alu_corners();
    test_random_alu();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
